// File: rtl/button_conditioner_pkg.sv
// Shared constants for the push-button front end: channel indices and
// default debounce timing used by the conditioner and its channels.
package button_conditioner_pkg;

   localparam int BTN_START_STOP = 0;
   localparam int BTN_LAP        = 1;
   localparam int BTN_CLEAR      = 2;

   localparam int DEFAULT_N_BUTTONS       = 3;
   // 10 ms of stability at the nominal 1 MHz clock
   localparam int DEFAULT_DEBOUNCE_CYCLES = 10000;
   localparam int DEFAULT_CNT_W           = 14;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchronizer, hold-time debouncer and
// registered press/release pulses derived from the accepted level.
module debounce_channel
   import button_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int CNT_W           = DEFAULT_CNT_W
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ena,
   input  logic i_raw,
   output logic o_level,
   output logic o_press,
   output logic o_release
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_stable;
   logic             r_press;
   logic             r_release;
   logic [CNT_W-1:0] r_cnt;

   logic [CNT_W-1:0] w_cntNext;
   logic             w_stableNext;
   logic             w_pressNext;
   logic             w_releaseNext;

   // The synchronizer ignores ena so the sampled level is always current
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
      end
   end

   // Any return to the stable level restarts the hold count from zero
   always_comb begin
      w_cntNext     = r_cnt;
      w_stableNext  = r_stable;
      w_pressNext   = 1'b0;
      w_releaseNext = 1'b0;
      if (ena) begin
         if (r_sync2 == r_stable) begin
            w_cntNext = '0;
         end else if (r_cnt == CNT_LAST) begin
            w_cntNext     = '0;
            w_stableNext  = r_sync2;
            w_pressNext   = r_sync2;
            w_releaseNext = !r_sync2;
         end else begin
            w_cntNext = r_cnt + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt     <= '0;
         r_stable  <= 1'b0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
      end else begin
         r_cnt     <= w_cntNext;
         r_stable  <= w_stableNext;
         r_press   <= w_pressNext;
         r_release <= w_releaseNext;
      end
   end

   assign o_level   = r_stable;
   assign o_press   = r_press;
   assign o_release = r_release;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the raw stopwatch push-buttons into clean clk-domain levels
// and single-cycle press/release pulses, one independent channel per button.
module button_conditioner
   import button_conditioner_pkg::*;
#(
   parameter int N_BUTTONS       = DEFAULT_N_BUTTONS,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int CNT_W           = DEFAULT_CNT_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ena,
   input  logic [N_BUTTONS-1:0] btn_raw,
   output logic [N_BUTTONS-1:0] btn_level,
   output logic [N_BUTTONS-1:0] btn_press,
   output logic [N_BUTTONS-1:0] btn_release
);

   for (genvar g = 0; g < N_BUTTONS; g++) begin : g_channel
      debounce_channel #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .CNT_W          (CNT_W)
      ) u_channel (
         .clk      (clk),
         .rst_n    (rst_n),
         .ena      (ena),
         .i_raw    (btn_raw[g]),
         .o_level  (btn_level[g]),
         .o_press  (btn_press[g]),
         .o_release(btn_release[g])
      );
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with a 4-cycle debounce: directed vectors,
// multi-cycle corner sequences and random traffic against a reference model.
module tb_button_conditioner;
   import button_conditioner_pkg::*;

   localparam int D = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b0;
   logic [2:0] btn_raw = 3'b000;
   logic [2:0] btn_level;
   logic [2:0] btn_press;
   logic [2:0] btn_release;

   int checks = 0;
   int failures = 0;

   button_conditioner #(
      .N_BUTTONS      (3),
      .DEBOUNCE_CYCLES(D),
      .CNT_W          (14)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .btn_raw    (btn_raw),
      .btn_level  (btn_level),
      .btn_press  (btn_press),
      .btn_release(btn_release)
   );

   always #5 clk = ~clk;

   // Reference model: a level is accepted once D consecutive enabled edges
   // have seen (two-edge delayed) raw samples that differ from it.
   logic [2:0] rawHist[$];
   logic [2:0] enHist[$];
   int         lastAcc[3];
   logic [2:0] mLevel;
   logic [2:0] mPress;
   logic [2:0] mRelease;

   task automatic modelReset();
      rawHist = '{3'b000, 3'b000};
      enHist.delete();
      for (int ch = 0; ch < 3; ch++) lastAcc[ch] = 0;
      mLevel   = '0;
      mPress   = '0;
      mRelease = '0;
   endtask

   task automatic modelEdge();
      logic [2:0] seen;
      bit         allDiff;
      seen = rawHist[1];
      rawHist.push_front(btn_raw);
      void'(rawHist.pop_back());
      mPress   = '0;
      mRelease = '0;
      if (ena) begin
         enHist.push_back(seen);
         for (int ch = 0; ch < 3; ch++) begin
            if (enHist.size() - lastAcc[ch] >= D) begin
               allDiff = 1'b1;
               for (int k = enHist.size() - D; k < enHist.size(); k++)
                  if (enHist[k][ch] == mLevel[ch]) allDiff = 1'b0;
               if (allDiff) begin
                  mLevel[ch] = seen[ch];
                  if (seen[ch]) mPress[ch] = 1'b1;
                  else          mRelease[ch] = 1'b1;
                  lastAcc[ch] = enHist.size();
               end
            end
         end
      end
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   // One clock: model follows the edge, DUT compared on the falling edge
   task automatic tick();
      @(posedge clk);
      modelEdge();
      @(negedge clk);
      checkOutput("model_level",   int'(btn_level),   int'(mLevel));
      checkOutput("model_press",   int'(btn_press),   int'(mPress));
      checkOutput("model_release", int'(btn_release), int'(mRelease));
   endtask

   task automatic applyStimulus(input logic [2:0] raw, input logic en);
      btn_raw = raw;
      ena     = en;
      tick();
   endtask

   typedef struct {
      logic       ena;
      logic [2:0] raw;
      logic [2:0] expLevel;
      logic [2:0] expPress;
      logic [2:0] expRelease;
   } vec_t;

   vec_t vecs[30];

   initial begin
      int         pressCnt;
      int         pressAt;
      int         releaseCnt;
      int         releaseAt;
      int         levelSeen;
      logic [2:0] pressVal;
      logic [2:0] cur;
      logic [2:0] flip;
      logic       en;
      logic       bouncePat[8];

      // Clean press on start/stop, held 20 cycles, then released
      for (int i = 0; i < 30; i++) begin
         vecs[i].ena        = 1'b1;
         vecs[i].raw        = (i < 20) ? 3'b001 : 3'b000;
         vecs[i].expPress   = (i == 5)  ? 3'b001 : 3'b000;
         vecs[i].expRelease = (i == 25) ? 3'b001 : 3'b000;
         vecs[i].expLevel   = (i >= 5 && i < 25) ? 3'b001 : 3'b000;
      end
      bouncePat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

      modelReset();
      repeat (2) @(negedge clk);
      checkOutput("reset_level",   int'(btn_level),   0);
      checkOutput("reset_press",   int'(btn_press),   0);
      checkOutput("reset_release", int'(btn_release), 0);
      rst_n = 1'b1;

      for (int i = 0; i < 30; i++) begin
         applyStimulus(vecs[i].raw, vecs[i].ena);
         checkOutput($sformatf("vec%0d_level", i),   int'(btn_level),   int'(vecs[i].expLevel));
         checkOutput($sformatf("vec%0d_press", i),   int'(btn_press),   int'(vecs[i].expPress));
         checkOutput($sformatf("vec%0d_release", i), int'(btn_release), int'(vecs[i].expRelease));
      end

      $display("[TB] bounce on lap");
      pressCnt = 0; pressAt = 0; releaseCnt = 0;
      for (int j = 1; j <= 22; j++) begin
         cur = 3'b000;
         cur[BTN_LAP] = (j <= 8) ? bouncePat[j-1] : 1'b1;
         applyStimulus(cur, 1'b1);
         if (btn_press[BTN_LAP]) begin pressCnt++; pressAt = j; end
         if (btn_release[BTN_LAP]) releaseCnt++;
      end
      checkOutput("bounce_press_count", pressCnt, 1);
      checkOutput("bounce_press_cycle", pressAt, 14);
      checkOutput("bounce_release_count", releaseCnt, 0);
      repeat (12) applyStimulus(3'b000, 1'b1);

      $display("[TB] glitch rejection on clear");
      pressCnt = 0; levelSeen = 0;
      for (int j = 1; j <= 15; j++) begin
         applyStimulus((j <= 3) ? 3'b100 : 3'b000, 1'b1);
         if (btn_press[BTN_CLEAR]) pressCnt++;
         if (btn_level[BTN_CLEAR]) levelSeen++;
      end
      checkOutput("glitch_press_count", pressCnt, 0);
      checkOutput("glitch_level_seen", levelSeen, 0);
      repeat (10) applyStimulus(3'b100, 1'b1);
      checkOutput("held_clear_level", int'(btn_level[BTN_CLEAR]), 1);
      releaseCnt = 0; releaseAt = 0;
      for (int j = 1; j <= 12; j++) begin
         applyStimulus(3'b000, 1'b1);
         if (btn_release[BTN_CLEAR]) begin releaseCnt++; releaseAt = j; end
      end
      checkOutput("release_count", releaseCnt, 1);
      checkOutput("release_cycle", releaseAt, 6);

      $display("[TB] enable gating on start/stop");
      pressCnt = 0; pressAt = 0;
      for (int j = 1; j <= 16; j++) begin
         applyStimulus(3'b001, (j >= 5 && j <= 9) ? 1'b0 : 1'b1);
         if (btn_press[BTN_START_STOP]) begin pressCnt++; pressAt = j; end
      end
      checkOutput("ena_press_count", pressCnt, 1);
      checkOutput("ena_press_cycle", pressAt, 11);

      $display("[TB] asynchronous reset mid-count");
      for (int j = 1; j <= 5; j++) applyStimulus(3'b011, 1'b1);
      checkOutput("pre_reset_level", int'(btn_level), 1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async_reset_level",   int'(btn_level),   0);
      checkOutput("async_reset_press",   int'(btn_press),   0);
      checkOutput("async_reset_release", int'(btn_release), 0);
      modelReset();
      @(posedge clk);
      @(negedge clk);
      checkOutput("held_reset_level", int'(btn_level), 0);
      rst_n = 1'b1;
      pressCnt = 0; pressAt = 0; pressVal = '0;
      for (int j = 1; j <= 10; j++) begin
         applyStimulus(3'b011, 1'b1);
         if (btn_press != 3'b000) begin pressCnt++; pressAt = j; pressVal = btn_press; end
      end
      checkOutput("post_reset_press_count", pressCnt, 1);
      checkOutput("post_reset_press_cycle", pressAt, 6);
      checkOutput("post_reset_press_value", int'(pressVal), 3);
      repeat (12) applyStimulus(3'b000, 1'b1);

      $display("[TB] simultaneous press");
      pressCnt = 0; pressAt = 0; pressVal = '0;
      for (int j = 1; j <= 12; j++) begin
         applyStimulus(3'b111, 1'b1);
         if (btn_press != 3'b000) begin pressCnt++; pressAt = j; pressVal = btn_press; end
         if (j == 7) checkOutput("simul_level", int'(btn_level), 7);
      end
      checkOutput("simul_press_count", pressCnt, 1);
      checkOutput("simul_press_cycle", pressAt, 6);
      checkOutput("simul_press_value", int'(pressVal), 7);
      repeat (12) applyStimulus(3'b000, 1'b1);

      $display("[TB] random traffic");
      cur = 3'b000;
      for (int j = 0; j < 500; j++) begin
         if ($urandom_range(0, 5) == 0) begin
            flip = 3'($urandom_range(1, 7));
            cur  = cur ^ flip;
         end
         en = ($urandom_range(0, 9) != 0);
         applyStimulus(cur, en);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Front-end stage directly upstream of the stopwatch controller. It conditions the raw push-button inputs (start/stop, lap, clear) into clean, clock-synchronous signals. Each button passes through a two-flop synchronizer and a counter-based debouncer, then an edge detector. The block emits single-cycle press and release pulses plus a stable level, so downstream logic runs on clk and never on button edges.

Parameters:
N_BUTTONS, 3, number of independent button channels (bit 0 start/stop, 1 lap, 2 clear)
DEBOUNCE_CYCLES, 10000, consecutive clk cycles a new synchronized level must hold before acceptance (10 ms at 1 MHz); legal range 2..2^CNT_W-1
CNT_W, 14, width of the per-channel debounce counter

Ports:
clk  input  1  system clock, 1 MHz nominal
rst_n  input  1  asynchronous active-low reset
ena  input  1  design enable; when low, counters hold and no pulses are emitted
btn_raw  input  N_BUTTONS  raw asynchronous button levels, active high
btn_level  output  N_BUTTONS  debounced stable level per channel
btn_press  output  N_BUTTONS  one-cycle pulse on an accepted 0->1 transition
btn_release  output  N_BUTTONS  one-cycle pulse on an accepted 1->0 transition

Behaviour:
- Reset: asynchronous on rst_n low. All synchronizer flops, stable levels, counters, btn_level, btn_press and btn_release go to 0 immediately. A button held through reset release is accepted as a press after the normal latency.
- Synchronizer: per channel, sync1 <= btn_raw and sync2 <= sync1 on every clk edge, independent of ena.
- Debounce, per channel, on each clk edge with ena=1:
  - If sync2 == stable: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable <= sync2 and cnt <= 0. Pulse btn_press if sync2=1, otherwise btn_release.
  - Else: cnt <= cnt+1.
- Any single-cycle return of sync2 to the stable value restarts the count from 0, so a glitch shorter than DEBOUNCE_CYCLES never passes.
- ena=0: cnt and stable hold, press/release are forced 0, and the synchronizer keeps running.
- Latency: btn_raw rises and stays high, first sampled at edge 1. btn_level and btn_press go high after edge DEBOUNCE_CYCLES+2. Release uses the same latency.
- btn_press and btn_release are registered and high for exactly one cycle per accepted transition. They are never both high on one channel in the same cycle.
- Counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around.
- Channels are fully independent. Simultaneous transitions on several channels produce simultaneous pulses.
- btn_level equals the registered stable value.

Decomposition:
- Shared package: button index constants BTN_START_STOP=0, BTN_LAP=1, BTN_CLEAR=2; default DEBOUNCE_CYCLES and CNT_W.
- One sub-module, debounce_channel: 1-bit synchronizer, counter, stable register and edge pulses, with the same clk/rst_n/ena.
- Top instantiates N_BUTTONS copies in a generate loop.

Test Plan:
All scenarios run with DEBOUNCE_CYCLES=4.
- Clean press: btn_raw[0] goes 0->1 and holds 20 cycles -> btn_press[0] high for exactly 1 cycle, 6 cycles after the first sampling edge; btn_level[0]=1 from then on; other channels stay 0.
- Bounce: btn_raw[1] toggles 1,0,1,0 every 2 cycles, then holds 1 -> no pulse during the bouncing; one btn_press[1] exactly 6 cycles after the final rise.
- Glitch rejection: btn_raw[2] high for 3 cycles, then low -> no btn_press[2] and btn_level[2] stays 0. Then release a held button -> btn_release fires once, latency 6.
- ena gating: start a press, drop ena after 2 counting cycles for 5 cycles, then restore ena -> no pulse while ena=0; btn_press appears 2 counting cycles after ena returns (count resumed, not restarted).
- Async reset mid-count: assert rst_n low between clock edges with cnt=3 and btn_level=1 -> all outputs 0 before the next edge. After rst_n deasserts with the button still held, btn_press occurs at 6-cycle latency.
- Simultaneous: all three btn_raw rise on the same cycle -> btn_press=3'b111 for one cycle, then btn_level=3'b111.
